// File: rtl/serial_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_frame
// Purpose  : UART transmitter. Sends one word per frame: start bit, data LSB
//            first, optional parity bit, then one or two stop bits. A
//            one-entry holding register lets the next word queue while the
//            current frame is on the line, so frames can run back-to-back.
//            block_tx holds off new frame starts but never cuts a frame short.
// Ports    : clk       in   system clock, rising edge
//            rst       in   asynchronous active-low reset
//            tx        out  serial line, idles high, driven from a flop
//            block_tx  in   flow control; high prevents new frame starts
//            busy      out  hold_valid | block_q; writes accepted when low
//            data      in   word to send, sampled on accept
//            new_data  in   write strobe
//            done      out  one-cycle pulse after the last stop-bit cycle
// Revision : 1.0  initial release
// ============================================================================
module serial_tx_frame #(
    parameter int CLK_PER_BIT = 163,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 tx,
    input  logic                 block_tx,
    output logic                 busy,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 new_data,
    output logic                 done
);

    localparam int CTR_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CTR_W-1:0] CTR_LAST   = CTR_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] BIT_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = (STOP_BITS == 2);
    localparam logic             PARITY_EN  = (PARITY != 0);
    localparam logic             PARITY_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state, state_next;
    logic [CTR_W-1:0]     ctr, ctr_next;
    logic [IDX_W-1:0]     bit_idx, bit_next;
    logic                 stop_idx, stop_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] hold_reg, hold_next;
    logic                 hold_valid, hold_valid_next;
    logic                 block_q;
    logic                 tx_next;
    logic                 done_next;
    logic                 ctr_end;
    logic                 load;
    logic                 parity_bit;

    assign busy       = hold_valid | block_q;
    assign ctr_end    = (ctr == CTR_LAST);
    // Parity comes from the latched frame copy so live data changes cannot
    // corrupt a frame already on the line.
    assign parity_bit = (^shift_reg) ^ PARITY_ODD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ctr        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            block_q    <= 1'b0;
            tx         <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            ctr        <= ctr_next;
            bit_idx    <= bit_next;
            stop_idx   <= stop_next;
            shift_reg  <= shift_next;
            hold_reg   <= hold_next;
            hold_valid <= hold_valid_next;
            block_q    <= block_tx;
            tx         <= tx_next;
            done       <= done_next;
        end
    end

    // tx_next is the line level for the cycle after the edge, so every
    // transition below also chooses the level of the bit being entered.
    always_comb begin
        state_next      = state;
        ctr_next        = ctr;
        bit_next        = bit_idx;
        stop_next       = stop_idx;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid;
        tx_next         = tx;
        done_next       = 1'b0;
        load            = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_next  = 1'b1;
                ctr_next = '0;
                if (hold_valid && !block_q) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (ctr_end) begin
                    state_next = ST_DATA;
                    ctr_next   = '0;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                end else begin
                    ctr_next = ctr + 1'b1;
                end
            end
            ST_DATA: begin
                if (ctr_end) begin
                    ctr_next = '0;
                    if (bit_idx == BIT_LAST) begin
                        if (PARITY_EN) begin
                            state_next = ST_PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = ST_STOP;
                            stop_next  = 1'b0;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next = bit_idx + 1'b1;
                        tx_next  = shift_reg[bit_next];
                    end
                end else begin
                    ctr_next = ctr + 1'b1;
                end
            end
            ST_PARITY: begin
                if (ctr_end) begin
                    state_next = ST_STOP;
                    ctr_next   = '0;
                    stop_next  = 1'b0;
                    tx_next    = 1'b1;
                end else begin
                    ctr_next = ctr + 1'b1;
                end
            end
            ST_STOP: begin
                if (ctr_end) begin
                    ctr_next = '0;
                    if (stop_idx == STOP_LAST) begin
                        done_next = 1'b1;
                        // A queued word starts on this same edge so the
                        // next start bit directly follows the stop bit.
                        if (hold_valid && !block_q) begin
                            load = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        stop_next = 1'b1;
                    end
                end else begin
                    ctr_next = ctr + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ctr_next   = '0;
                tx_next    = 1'b1;
            end
        endcase

        if (load) begin
            shift_next      = hold_reg;
            hold_valid_next = 1'b0;
            state_next      = ST_START;
            ctr_next        = '0;
            tx_next         = 1'b0;
        end

        // Accepting needs hold_valid low, so it can never collide with a load.
        if (new_data && !busy) begin
            hold_next       = data;
            hold_valid_next = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_tx_frame.md
# serial_tx_frame

Parametrised UART transmitter for the control board's serial links. It serialises one word per frame with configurable data width, parity mode and stop-bit count. A one-entry holding register allows the next word to be queued while the current frame is on the line, so consecutive frames are sent back-to-back with no idle bit time. `block_tx` can hold off new frames (flow control) without truncating a frame in progress.

## Interface
- `CLK_PER_BIT`, 163: clock cycles per bit period; legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `tx`  out  1  serial line; idles high.
- `block_tx`  in  1  when high, no new frame may start; registered internally as `block_q`.
- `busy`  out  1  `hold_valid | block_q`; `new_data` is accepted only when low.
- `data`  in  DATA_BITS  word to send; sampled on accept.
- `new_data`  in  1  write strobe.
- `done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- Accept: on an edge where `new_data=1` and `busy=0`, `data` goes to the holding register and `hold_valid` is set. If `new_data=1` while `busy=1`, the word is dropped silently with no state change.
- States: IDLE, START, DATA, PARITY, STOP. Bit counter `ctr` is `$clog2(CLK_PER_BIT)` bits wide; the bit index covers 0..DATA_BITS-1 and the stop index covers 0..STOP_BITS-1.
- IDLE: `tx=1`. If `hold_valid` and not `block_q`, the holding register moves to the shift register, `hold_valid` clears, and the state goes to START.
- START: `tx=0` for CLK_PER_BIT cycles, then DATA.
- DATA: sends LSB first, CLK_PER_BIT cycles per bit. After bit DATA_BITS-1, go to PARITY if PARITY≠0, otherwise STOP.
- PARITY: `tx` = XOR of all data bits (even mode) or its inverse (odd mode), for CLK_PER_BIT cycles.
- STOP: `tx=1` for STOP_BITS×CLK_PER_BIT cycles. At the end:
  - `done` pulses.
  - If `hold_valid` and not `block_q`, load the holding register and go straight to START (no idle cycle).
  - Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_PER_BIT cycles.
- `block_tx` affects only frame starts. A frame already past IDLE always completes. A held word stays held while blocked.
- Parity is computed from the shift-register copy, not from live `data`.
- Unused state encodings return to IDLE with `tx=1`.

## Timing
- Reset (asynchronous, immediate, no clock needed):
  - `tx=1`, `busy=0`, `done=0`.
  - state = IDLE, `hold_valid=0`, `block_q=0`, counters = 0.
- Reset mid-frame aborts the frame; `tx` returns high at once and no `done` pulse is generated.
- `tx` is driven from a flop, so no glitches.
- Latency from idle: accept at edge E0 → `hold_valid=1` after E0 → START entered and `tx` falls at E1. `busy` is high for exactly one cycle (E0 to E1) when unblocked.
- Back-to-back:
  - After the frame start at E1, `busy` is low, so a second word may be accepted immediately.
  - Its start bit begins on the edge that ends the last stop bit.
  - `busy` stays high from that accept until that edge.
- `done`: registered, high for the single cycle following the last stop-bit cycle. This coincides with the first cycle of IDLE or of the next START.
- Blocking: `block_tx` deasserted before edge Ek → `block_q=0` after Ek → a pending frame starts at Ek+1.
- An accept and a frame end on the same edge do not conflict: the accept requires `hold_valid=0`.

## Test plan
- Reset and single frame:
  - Stimulus: reset held low → release; then CLK_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, send 0x55.
  - Response: `tx=1`, `busy=0`, `done=0` during and after reset; `tx` = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; `done` pulses 40 cycles after `tx` falls.
- Back-to-back:
  - Stimulus: same parameters; send 0xA5, then 0x3C on the first cycle `busy` is low.
  - Response: 0x3C's start bit immediately follows 0xA5's stop bit; 80 contiguous cycles with no idle high gap; two `done` pulses 40 cycles apart.
- Parity and stop bits:
  - Stimulus: DATA_BITS=7, PARITY=2, STOP_BITS=2, send 7'h41.
  - Response: parity bit = 1; 11 bit periods; stop level held 2×CLK_PER_BIT cycles.
  - Repeat with PARITY=1: parity bit = 0.
- Flow control:
  - Stimulus: assert `block_tx` mid-frame and queue 0x12.
  - Response: current frame completes; `tx` stays 1 and `busy` stays 1 while blocked; after deassert, 0x12's start bit appears 2 edges later.
- Dropped write:
  - Stimulus: queue 0x77, then pulse `new_data` with 0x99 while `busy=1`.
  - Response: only 0x77 is transmitted; 0x99 never appears.
- Reset mid-frame:
  - Stimulus: pull `rst` low during bit 3 of DATA, with no clock edge.
  - Response: `tx=1` and `busy=0` at once; no `done`; after release, a fresh 0x0F frame is sent correctly.
